// File: rtl/whack_detector.sv
// rtl/whack_detector.sv - debounces KEY presses, scores hits/misses against mole_active, retires whacked moles
// Hit/miss/escape scoring with saturating score and miss count; PLAY/OVER game state.
module whack_detector #(
  parameter int N_MOLES         = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SCORE_W         = 10,
  parameter int MAX_MISSES      = 9
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [N_MOLES-1:0] key_n,
  input  logic [N_MOLES-1:0] mole_active,
  input  logic [1:0]         level,
  output logic [N_MOLES-1:0] mole_clear,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         misses,
  output logic               game_over
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HCNT_W = $clog2(N_MOLES + 1);
  localparam int MCNT_W = $clog2(2 * N_MOLES + 1);
  localparam int SSUM_W = SCORE_W + $clog2(4 * N_MOLES + 1);
  localparam int MSUM_W = 4 + MCNT_W;

  typedef enum logic [1:0] {DB_RELEASED, DB_PRESS_WAIT, DB_HELD, DB_REL_WAIT} db_state_t;
  typedef enum logic {G_PLAY, G_OVER} game_state_t;

  logic [N_MOLES-1:0] w_press_evt;

  for (genvar gi = 0; gi < N_MOLES; gi++) begin : gen_key
    logic         r_sync1, r_sync2, r_armed, r_evt;
    db_state_t    r_state;
    logic [CNT_W-1:0] r_cnt;

    // Sync flops reset to "pressed" and r_armed gates entry to PRESS_WAIT, so a key
    // held through reset must be observed released before it can register a press.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
        r_armed <= 1'b0;
        r_evt   <= 1'b0;
        r_state <= DB_RELEASED;
        r_cnt   <= '0;
      end else begin
        r_sync1 <= key_n[gi];
        r_sync2 <= r_sync1;
        r_evt   <= 1'b0;
        case (r_state)
          DB_RELEASED: begin
            if (r_sync2) begin
              r_armed <= 1'b1;
            end else if (r_armed) begin
              r_state <= DB_PRESS_WAIT;
              r_cnt   <= CNT_W'(1);
            end
          end
          DB_PRESS_WAIT: begin
            if (r_sync2) begin
              r_state <= DB_RELEASED;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
              r_state <= DB_HELD;
              r_evt   <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          DB_HELD: begin
            if (r_sync2) begin
              r_state <= DB_REL_WAIT;
              r_cnt   <= CNT_W'(1);
            end
          end
          DB_REL_WAIT: begin
            if (!r_sync2) begin
              r_state <= DB_HELD;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
              r_state <= DB_RELEASED;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: r_state <= DB_RELEASED;
        endcase
      end
    end

    assign w_press_evt[gi] = r_evt;
  end

  game_state_t        r_game;
  logic [N_MOLES-1:0] r_mole_prev, r_hit_pending, r_mole_clear;
  logic               r_hit_pulse, r_miss_pulse;
  logic [SCORE_W-1:0] r_score;
  logic [3:0]         r_misses;

  logic [N_MOLES-1:0] w_hit, w_empty, w_fall, w_escape;
  logic [HCNT_W-1:0]  w_n_hits;
  logic [MCNT_W-1:0]  w_n_miss;
  logic [SSUM_W-1:0]  w_score_sum;
  logic [MSUM_W-1:0]  w_miss_sum;
  logic [SCORE_W-1:0] w_score_next;
  logic [3:0]         w_misses_next;

  always_comb begin
    w_hit    = w_press_evt & mole_active;
    w_empty  = w_press_evt & ~mole_active;
    w_fall   = r_mole_prev & ~mole_active;
    w_escape = w_fall & ~r_hit_pending;
    w_n_hits = '0;
    w_n_miss = '0;
    for (int i = 0; i < N_MOLES; i++) begin
      w_n_hits = w_n_hits + HCNT_W'(w_hit[i]);
      w_n_miss = w_n_miss + MCNT_W'(w_empty[i]) + MCNT_W'(w_escape[i]);
    end
    w_score_sum = SSUM_W'(r_score) + SSUM_W'(w_n_hits) * (SSUM_W'(level) + SSUM_W'(1));
    w_miss_sum  = MSUM_W'(r_misses) + MSUM_W'(w_n_miss);
    w_score_next  = (w_score_sum > SSUM_W'({SCORE_W{1'b1}})) ? {SCORE_W{1'b1}} : w_score_sum[SCORE_W-1:0];
    w_misses_next = (w_miss_sum >= MSUM_W'(MAX_MISSES)) ? 4'(MAX_MISSES) : w_miss_sum[3:0];
  end

  // A mole that falls after being hit only retires its pending flag; start drops same-cycle events.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_game        <= G_PLAY;
      r_mole_prev   <= '0;
      r_hit_pending <= '0;
      r_mole_clear  <= '0;
      r_hit_pulse   <= 1'b0;
      r_miss_pulse  <= 1'b0;
      r_score       <= '0;
      r_misses      <= '0;
    end else begin
      r_mole_prev   <= mole_active;
      r_mole_clear  <= '0;
      r_hit_pulse   <= 1'b0;
      r_miss_pulse  <= 1'b0;
      r_hit_pending <= r_hit_pending & ~w_fall;
      if (start) begin
        r_game        <= G_PLAY;
        r_score       <= '0;
        r_misses      <= '0;
        r_hit_pending <= '0;
      end else if (r_game == G_PLAY) begin
        r_mole_clear  <= w_hit;
        r_hit_pulse   <= |w_hit;
        r_miss_pulse  <= |(w_empty | w_escape);
        r_hit_pending <= (r_hit_pending & ~w_fall) | w_hit;
        r_score       <= w_score_next;
        r_misses      <= w_misses_next;
        if (w_misses_next >= 4'(MAX_MISSES)) r_game <= G_OVER;
      end
    end
  end

  assign mole_clear = r_mole_clear;
  assign hit_pulse  = r_hit_pulse;
  assign miss_pulse = r_miss_pulse;
  assign score      = r_score;
  assign misses     = r_misses;
  assign game_over  = (r_game == G_OVER);

endmodule

// File: tb/tb_whack_detector.sv
// tb/tb_whack_detector.sv - directed self-checking bench for whack_detector
// Debounce of 4 cycles; inputs change 1 time unit after each rising edge.
module tb_whack_detector;
  logic       clk = 1'b0;
  logic       reset_n, start;
  logic [3:0] key_n, mole_active, mole_clear;
  logic [1:0] level;
  logic       hit_pulse, miss_pulse, game_over;
  logic [9:0] score;
  logic [3:0] misses;

  int n_checks = 0;
  int n_fail   = 0;

  whack_detector #(.N_MOLES(4), .DEBOUNCE_CYCLES(4), .SCORE_W(10), .MAX_MISSES(9)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .key_n(key_n),
    .mole_active(mole_active), .level(level), .mole_clear(mole_clear),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .score(score),
    .misses(misses), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Press keys with moles showing; key edge is 0, scoring lands on edge 7; then release all.
  task automatic do_press(input logic [3:0] keys, input logic [3:0] moles,
                          output logic [3:0] pre_clr, output logic [3:0] clr,
                          output logic hp, output logic mp);
    mole_active = moles;
    key_n       = ~keys;
    repeat (6) tick();
    pre_clr = mole_clear;
    tick();
    clr = mole_clear;
    hp  = hit_pulse;
    mp  = miss_pulse;
    repeat (3) tick();
    key_n       = 4'hF;
    mole_active = 4'h0;
    repeat (8) tick();
  endtask

  initial begin
    logic [3:0] pre, clr, seen_clr;
    logic       hp, mp;
    int         hits;
    logic [7:0] bounce;

    reset_n = 1'b0; start = 1'b0; key_n = 4'hF; mole_active = 4'h0; level = 2'd0;
    repeat (3) tick();
    chk("rst_mole_clear", 32'(mole_clear), 0);
    chk("rst_hit_pulse", 32'(hit_pulse), 0);
    chk("rst_miss_pulse", 32'(miss_pulse), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_misses", 32'(misses), 0);
    chk("rst_game_over", 32'(game_over), 0);
    reset_n = 1'b1;
    repeat (6) tick();

    // 1: single hit, level 0, latency D+3
    do_press(4'b0001, 4'b0001, pre, clr, hp, mp);
    chk("t1_clear_edge6", 32'(pre), 0);
    chk("t1_clear_edge7", 32'(clr), 32'b0001);
    chk("t1_hit_pulse", 32'(hp), 1);
    chk("t1_score", 32'(score), 1);
    chk("t1_no_escape_miss", 32'(misses), 0);

    // 2: bouncing key yields exactly one hit
    bounce = 8'b0000_0101;
    hits = 0;
    mole_active = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      key_n = 4'hF;
      key_n[1] = (c < 8) ? bounce[c] : 1'b0;
      tick();
      if (hit_pulse) hits++;
    end
    key_n = 4'hF; mole_active = 4'h0;
    repeat (8) tick();
    chk("t2_hit_count", 32'(hits), 1);
    chk("t2_score", 32'(score), 2);
    chk("t2_misses", 32'(misses), 0);

    // 3: two simultaneous hits at level 3
    level = 2'd3;
    do_press(4'b0101, 4'b0101, pre, clr, hp, mp);
    chk("t3_clear", 32'(clr), 32'b0101);
    chk("t3_score", 32'(score), 10);
    chk("t3_misses", 32'(misses), 0);

    // 4: escape then empty whack
    mole_active = 4'b1000; tick();
    mole_active = 4'b0000; tick();
    chk("t4_escape_pulse", 32'(miss_pulse), 1);
    chk("t4_escape_misses", 32'(misses), 1);
    tick();
    chk("t4_pulse_one_cycle", 32'(miss_pulse), 0);
    do_press(4'b0010, 4'b0000, pre, clr, hp, mp);
    chk("t4_empty_pulse", 32'(mp), 1);
    chk("t4_empty_nohit", 32'(hp), 0);
    chk("t4_empty_misses", 32'(misses), 2);
    chk("t4_score_kept", 32'(score), 10);

    // 5: reach nine misses, frozen in OVER, start recovers
    for (int k = 0; k < 7; k++) begin
      mole_active = 4'b0001; tick();
      mole_active = 4'b0000; tick();
      if (k == 5) begin
        chk("t5_misses8", 32'(misses), 8);
        chk("t5_not_over", 32'(game_over), 0);
      end
    end
    chk("t5_misses9", 32'(misses), 9);
    chk("t5_game_over", 32'(game_over), 1);
    do_press(4'b0001, 4'b0001, pre, clr, hp, mp);
    chk("t5_over_clear", 32'(clr), 0);
    chk("t5_over_hit", 32'(hp), 0);
    chk("t5_over_score", 32'(score), 10);
    chk("t5_over_misses", 32'(misses), 9);
    start = 1'b1; tick(); start = 1'b0;
    chk("t5_start_score", 32'(score), 0);
    chk("t5_start_misses", 32'(misses), 0);
    chk("t5_start_play", 32'(game_over), 0);

    // 6: saturation at 1023 (level 3)
    for (int k = 0; k < 63; k++) do_press(4'hF, 4'hF, pre, clr, hp, mp);
    chk("t6_score1008", 32'(score), 1008);
    for (int k = 0; k < 3; k++) do_press(4'b0001, 4'b0001, pre, clr, hp, mp);
    chk("t6_score1020", 32'(score), 1020);
    do_press(4'b0001, 4'b0001, pre, clr, hp, mp);
    chk("t6_sat_clear", 32'(clr), 32'b0001);
    chk("t6_sat_score", 32'(score), 1023);
    do_press(4'hF, 4'hF, pre, clr, hp, mp);
    chk("t6_sat_hold", 32'(score), 1023);
    chk("t6_misses", 32'(misses), 0);

    // 6: reset while a key is held; held key must be released before it counts
    mole_active = 4'b0001; key_n = 4'b1110;
    repeat (3) tick();
    reset_n = 1'b0; #1;
    chk("t6_rst_score", 32'(score), 0);
    chk("t6_rst_misses", 32'(misses), 0);
    chk("t6_rst_clear", 32'(mole_clear), 0);
    tick();
    reset_n = 1'b1;
    seen_clr = 4'h0;
    for (int c = 0; c < 12; c++) begin
      tick();
      seen_clr = seen_clr | mole_clear;
    end
    chk("t6_held_no_clear", 32'(seen_clr), 0);
    chk("t6_held_no_score", 32'(score), 0);
    key_n = 4'hF; mole_active = 4'h0;
    repeat (8) tick();
    do_press(4'b0001, 4'b0001, pre, clr, hp, mp);
    chk("t6_repress_clear", 32'(clr), 32'b0001);
    chk("t6_repress_score", 32'(score), 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
